// File: rtl/bcd_scan_mux.sv
// Four-digit BCD scanner. It rotates the held digits onto one shared decoder input and drives
// active-low anodes, with optional leading-zero blanking and a per-frame tick.
module bcd_scan_mux #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [15:0]   held_q, held_d;
  logic          lz_q, lz_d;
  logic [3:0]    bcd_q, bcd_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q, tick_d;

  logic          boundary;
  logic [1:0]    slot_nxt;
  logic [15:0]   upper;
  logic          blank;

  always_comb begin
    boundary = (cnt_q == CW'(DIV - 1));
    slot_nxt = slot_q + 2'd1;
    // Digits from the new slot upward; all-zero means this digit is a leading zero.
    upper    = held_q >> {slot_nxt, 2'b00};
    blank    = lz_q && (slot_nxt != 2'd0) && (upper == 16'h0000);

    cnt_d    = boundary ? '0 : cnt_q + CW'(1);
    slot_d   = slot_q;
    held_d   = held_q;
    lz_d     = lz_q;
    bcd_d    = bcd_q;
    an_d     = an_q;
    tick_d   = 1'b0;

    if (load) begin
      held_d = digits_in;
      lz_d   = blank_lz;
    end

    // Boundary outputs use the pre-edge held/lz, so a coincident load shows next slot.
    if (boundary) begin
      slot_d = slot_nxt;
      tick_d = (slot_nxt == 2'd0);
      if (blank) begin
        bcd_d = 4'hF;
        an_d  = 4'b1111;
      end else begin
        bcd_d = upper[3:0];
        an_d  = ~(4'b0001 << slot_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      slot_q <= 2'd3;
      held_q <= 16'h0000;
      lz_q   <= 1'b0;
      bcd_q  <= 4'hF;
      an_q   <= 4'b1111;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      held_q <= held_d;
      lz_q   <= lz_d;
      bcd_q  <= bcd_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign bcd        = bcd_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Bench for bcd_scan_mux. Directed and random steps are checked against an edge-counting
// reference model that works from digit arithmetic.
module tb_bcd_scan_mux;

  localparam int unsigned DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        frame_tick;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int          m_e;      // edges with rst_n=1 since the last reset
  int          m_shown;  // slot currently shown, -1 while dark after reset
  logic [15:0] m_held;
  logic        m_lz;
  logic [3:0]  m_bcd;
  logic [3:0]  m_an;
  logic        m_tick;

  bcd_scan_mux #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Display value for slot s: dark when it is a leading zero under blanking.
  task automatic disp(input logic [15:0] h, input logic lzv, input int s,
                      output logic [3:0] b, output logic [3:0] a);
    int hv;
    int above;
    hv    = int'(h);
    above = hv / (1 << (4 * s));
    if (lzv && s > 0 && above == 0) begin
      b = 4'hF;
      a = 4'b1111;
    end else begin
      b = 4'(above % 16);
      a = 4'b1111;
      a[s] = 1'b0;
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input logic [15:0] d, input bit blz);
    int s;
    rst_n     = r;
    load      = ld;
    digits_in = d;
    blank_lz  = blz;
    @(posedge clk);
    if (!r) begin
      m_e = 0; m_shown = -1; m_held = 16'h0; m_lz = 1'b0;
      m_bcd = 4'hF; m_an = 4'b1111; m_tick = 1'b0;
    end else begin
      m_e++;
      m_tick = 1'b0;
      if (m_e % DIV == 0) begin
        s = ((m_e / DIV) - 1) % 4;
        disp(m_held, m_lz, s, m_bcd, m_an);
        m_shown = s;
        m_tick  = (s == 0);
      end
      if (ld) begin
        m_held = d;
        m_lz   = blz;
      end
    end
    #1;
    chk("bcd", bcd, m_bcd);
    chk("an", an, m_an);
    chk("frame_tick", {3'b000, frame_tick}, {3'b000, m_tick});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] rd;
    rst_n = 1'b0; load = 1'b0; digits_in = 16'h0; blank_lz = 1'b0;
    m_e = 0; m_shown = -1; m_held = 16'h0; m_lz = 1'b0;
    m_bcd = 4'hF; m_an = 4'b1111; m_tick = 1'b0;

    // Reset then first boundary on the DIV-th released edge
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    idle(DIV - 1);
    chk("dark_before_first_boundary", an, 4'b1111);
    idle(1);
    chk("first_bcd", bcd, 4'h0);
    chk("first_an", an, 4'b1110);
    chk("first_tick", {3'b000, frame_tick}, 4'b0001);

    // Scan order
    cyc(1'b1, 1'b1, 16'h1234, 1'b0);
    idle(8 * DIV);

    // Leading-zero blanking
    cyc(1'b1, 1'b1, 16'h0050, 1'b1);
    idle(8 * DIV);
    cyc(1'b1, 1'b1, 16'h0000, 1'b1);
    idle(8 * DIV);

    // Load exactly on a boundary edge
    cyc(1'b1, 1'b1, 16'h1111, 1'b0);
    idle(4 * DIV);
    for (int i = 0; i < 2 * DIV && (m_e % DIV) != DIV - 1; i++) idle(1);
    cyc(1'b1, 1'b1, 16'h9999, 1'b0);
    chk("boundary_load_old", bcd, 4'h1);
    idle(DIV - 1);
    chk("boundary_load_hold", bcd, 4'h1);
    idle(1);
    chk("boundary_load_new", bcd, 4'h9);

    // Non-decimal pass-through
    cyc(1'b1, 1'b1, 16'hA00C, 1'b1);
    idle(8 * DIV);

    // Reset mid-slot while digit2 shown, with load asserted
    for (int i = 0; i < 8 * DIV && !(m_shown == 2 && (m_e % DIV) == 1); i++) idle(1);
    chk("reached_digit2", an, 4'b1011);
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b1);
    chk("rst_bcd", bcd, 4'hF);
    chk("rst_an", an, 4'b1111);
    idle(DIV);
    chk("after_rst_d0", bcd, 4'h0);
    chk("after_rst_an0", an, 4'b1110);
    idle(DIV);
    chk("after_rst_d1", bcd, 4'h0);
    chk("after_rst_an1", an, 4'b1101);
    idle(2 * DIV);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rd = 16'($urandom) & 16'($urandom) & 16'($urandom);
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0), rd,
          1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
